mem_port_router: RTL

Single-ported unified-memory router for the pipelined RISC-V core. It arbitrates the instruction-fetch port (IF) and the data port (MEM stage) onto one memory port. It then steers each registered read response back to the requester that issued it. It is the demultiplexing, response-side counterpart of the core's select-type datapath muxes, and it sits between the IF/MEM stages and the unified memory.

---
 rtl/mem_port_router.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_port_router.sv
// mem_port_router
//
// Routes the instruction-fetch port and the data port of the pipelined
// RISC-V core onto one unified memory port. Each read response coming back
// from memory is sent to the requester that issued the read.
//
// Arbitration: the data port wins by default, because it belongs to the
// older instruction. The IF port wins when it is the only requester, or
// when it has been denied STARVE_MAX cycles in a row. In that forced case
// the data request is left pending.
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   if_req/addr   IF read request, held until if_gnt
//   if_gnt        IF request accepted this cycle
//   if_rvalid     IF read data valid (one cycle after the grant)
//   if_rdata      IF read data, zero when if_rvalid is low
//   stall_if      IF is requesting but was not granted (PC/IF stall)
//   d_req/we/be/addr/wdata
//                 data request, held until d_gnt
//   d_gnt         data request accepted this cycle
//   d_rvalid      data read data valid (reads only)
//   d_rdata       data read data, zero when d_rvalid is low
//   mem_en/we/be/addr/wdata
//                 unified memory request, all zero when idle
//   mem_rdata     memory read data, one cycle after a read access
module mem_port_router #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                stall_if,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starveCnt_q, starveCnt_d;
  logic       rdPending_q, rdPending_d;
  logic       rdOwner_q, rdOwner_d;
  logic       forceIf;
  logic       ifGnt;
  logic       dGnt;

  // Grant decision. Reset forces both grants low, so nothing reaches memory
  // while rst is high.
  always_comb begin
    forceIf = if_req & (starveCnt_q == STARVE_LIM);
    ifGnt   = ~rst & if_req & (~d_req | forceIf);
    dGnt    = ~rst & d_req & ~ifGnt;
  end

  assign if_gnt   = ifGnt;
  assign d_gnt    = dGnt;
  assign stall_if = ~rst & if_req & ~ifGnt;

  // Memory port mux. An IF access is always a full-word read.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ifGnt) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = if_addr;
    end else if (dGnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Next state. The starvation count covers consecutive denied IF cycles.
  // Saturating at the limit keeps the compare above exact.
  // The response tracker records whether this cycle issued a read and who
  // issued it.
  always_comb begin
    starveCnt_d = 4'd0;
    if (if_req & ~ifGnt) begin
      if (starveCnt_q == STARVE_LIM) begin
        starveCnt_d = STARVE_LIM;
      end else begin
        starveCnt_d = starveCnt_q + 4'd1;
      end
    end
    rdPending_d = mem_en & ~mem_we;
    rdOwner_d   = dGnt;
  end

  // State registers. An asynchronous reset drops any outstanding read
  // response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt_q <= 4'd0;
      rdPending_q <= 1'b0;
      rdOwner_q   <= 1'b0;
    end else begin
      starveCnt_q <= starveCnt_d;
      rdPending_q <= rdPending_d;
      rdOwner_q   <= rdOwner_d;
    end
  end

  // Response steering. Read data passes straight through from memory to the
  // port that owns the read. The other port sees zeros.
  always_comb begin
    if_rvalid = ~rst & rdPending_q & ~rdOwner_q;
    d_rvalid  = ~rst & rdPending_q & rdOwner_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

endmodule
